// File: rtl/vscale_hasti_sram_slave_pkg.sv
// HASTI bus constants, slave state encoding and transfer decode helpers
// shared by the scratchpad slave and its bench.
package vscale_hasti_sram_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_BUS_NBYTES  = HASTI_BUS_WIDTH / 8;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE     = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALFWORD = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD     = 3'd2;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_READY,
    S_WAIT,
    S_ERR,
    S_ERRDONE
  } slave_state_e;

  // Naturally aligned byte/half/word only; anything wider than a word is refused.
  function automatic logic hasti_legal(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                       input logic [1:0] lsb);
    case (size)
      HASTI_SIZE_BYTE:     return 1'b1;
      HASTI_SIZE_HALFWORD: return ~lsb[0];
      HASTI_SIZE_WORD:     return (lsb == 2'b00);
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [HASTI_BUS_NBYTES-1:0] hasti_lanes(
      input logic [HASTI_SIZE_WIDTH-1:0] size, input logic [1:0] lsb);
    case (size)
      HASTI_SIZE_BYTE:     return 4'b0001 << lsb;
      HASTI_SIZE_HALFWORD: return lsb[1] ? 4'b1100 : 4'b0011;
      default:             return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/vscale_sram_1rw_be.sv
// Word-wide synchronous RAM with per-byte write enables; a read in the same
// cycle as a write to the same word returns the old contents.
module vscale_sram_1rw_be #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI (AHB-lite) scratchpad slave: byte-lane writes, programmable wait
// states, two-cycle ERROR response and write-to-read forwarding.
module vscale_hasti_sram_slave
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hsel,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic                         hresp
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  slave_state_e                state_q;
  logic [1:0]                  wait_cnt_q;
  logic                        hready_q;
  logic                        hresp_q;
  logic                        wr_pend_q;
  logic [WORD_BITS-1:0]        wr_idx_q;
  logic [HASTI_BUS_NBYTES-1:0] wr_be_q;
  logic                        rd_fresh_q;
  logic [HASTI_BUS_NBYTES-1:0] fwd_be_q;
  logic [HASTI_BUS_WIDTH-1:0]  fwd_data_q;
  logic [HASTI_BUS_WIDTH-1:0]  hrdata_q;

  logic                        accept;
  logic                        xfer_legal;
  logic                        wr_commit;
  logic                        raw_hit;
  logic [WORD_BITS-1:0]        addr_idx;
  logic [HASTI_BUS_NBYTES-1:0] addr_be;
  logic [HASTI_BUS_NBYTES-1:0] sram_we;
  logic [HASTI_BUS_WIDTH-1:0]  sram_rdata;
  logic [HASTI_BUS_WIDTH-1:0]  rd_merged;
  logic                        unused_ok;

  assign unused_ok = ^{hburst, hmastlock, hprot, haddr[HASTI_ADDR_WIDTH-1:ADDR_BITS]};

  assign addr_idx   = haddr[ADDR_BITS-1:2];
  assign addr_be    = hasti_lanes(hsize, haddr[1:0]);
  assign xfer_legal = hasti_legal(hsize, haddr[1:0]);
  assign accept     = hsel && hready_q &&
                      (htrans == HASTI_TRANS_NONSEQ || htrans == HASTI_TRANS_SEQ);

  // A write data phase ends, and commits, on the first edge with hready high.
  assign wr_commit = wr_pend_q && hready_q;
  assign sram_we   = wr_commit ? wr_be_q : '0;
  assign raw_hit   = accept && xfer_legal && !hwrite && wr_commit && (addr_idx == wr_idx_q);

  vscale_sram_1rw_be #(
    .AW (WORD_BITS),
    .DW (HASTI_BUS_WIDTH)
  ) u_sram (
    .clk   (hclk),
    .we    (sram_we),
    .waddr (wr_idx_q),
    .wdata (hwdata),
    .raddr (addr_idx),
    .rdata (sram_rdata)
  );

  for (genvar gi = 0; gi < HASTI_BUS_NBYTES; gi++) begin : g_lane
    assign rd_merged[gi*8 +: 8] = fwd_be_q[gi] ? fwd_data_q[gi*8 +: 8] : sram_rdata[gi*8 +: 8];
  end

  // RAM output is only trusted the cycle after the read; afterwards the latched copy holds.
  assign hrdata = rd_fresh_q ? rd_merged : hrdata_q;
  assign hready = hready_q;
  assign hresp  = hresp_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_READY;
      wait_cnt_q <= 2'd0;
      hready_q   <= 1'b1;
      hresp_q    <= HASTI_RESP_OKAY;
      wr_pend_q  <= 1'b0;
      wr_idx_q   <= '0;
      wr_be_q    <= '0;
      rd_fresh_q <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
      hrdata_q   <= '0;
    end else begin
      if (wr_commit) wr_pend_q <= 1'b0;
      if (rd_fresh_q) hrdata_q <= rd_merged;
      rd_fresh_q <= 1'b0;

      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            state_q  <= S_READY;
            hready_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        S_ERR: begin
          state_q  <= S_ERRDONE;
          hready_q <= 1'b1;
          hresp_q  <= HASTI_RESP_ERROR;
        end
        default: begin
          state_q  <= S_READY;
          hready_q <= 1'b1;
          hresp_q  <= HASTI_RESP_OKAY;
        end
      endcase

      if (accept) begin
        if (!xfer_legal) begin
          state_q  <= S_ERR;
          hready_q <= 1'b0;
          hresp_q  <= HASTI_RESP_ERROR;
        end else begin
          hresp_q <= HASTI_RESP_OKAY;
          if (WAIT_STATES > 0) begin
            state_q    <= S_WAIT;
            hready_q   <= 1'b0;
            wait_cnt_q <= WAIT_LOAD;
          end
          if (hwrite) begin
            wr_pend_q <= 1'b1;
            wr_idx_q  <= addr_idx;
            wr_be_q   <= addr_be;
          end else begin
            rd_fresh_q <= 1'b1;
            fwd_be_q   <= raw_hit ? wr_be_q : '0;
            fwd_data_q <= hwdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for the scratchpad slave: one instance with no wait states, one with
// two, both checked every cycle against a transfer-level reference model.
module tb_vscale_hasti_sram_slave;
  import vscale_hasti_sram_slave_pkg::*;

  localparam int AB = 14;

  logic clk = 1'b0;
  logic hresetn;
  always #5 clk = ~clk;

  logic [1:0]       hsel_v;
  logic [1:0]       hwrite_v;
  logic [1:0][1:0]  htrans_v;
  logic [1:0][2:0]  hsize_v;
  logic [1:0][31:0] haddr_v;
  logic [1:0][31:0] hwdata_v;
  logic [2:0]       hburst_c    = 3'd0;
  logic             hmastlock_c = 1'b0;
  logic [3:0]       hprot_c     = 4'd0;

  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1, hresp0, hresp1;

  vscale_hasti_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
    .hwrite(hwrite_v[0]), .hsize(hsize_v[0]), .hburst(hburst_c),
    .hmastlock(hmastlock_c), .hprot(hprot_c), .htrans(htrans_v[0]),
    .hwdata(hwdata_v[0]), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  vscale_hasti_sram_slave #(.ADDR_BITS(AB), .WAIT_STATES(2)) dut1 (
    .hclk(clk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
    .hwrite(hwrite_v[1]), .hsize(hsize_v[1]), .hburst(hburst_c),
    .hmastlock(hmastlock_c), .hprot(hprot_c), .htrans(htrans_v[1]),
    .hwdata(hwdata_v[1]), .hrdata(hrdata1), .hready(hready1), .hresp(hresp1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (transfer level: memory words + response timeline)
  logic [31:0] m_mem [2][4096];
  logic        m_rdy   [2];
  logic        m_resp  [2];
  logic [31:0] m_rdata [2];
  int          m_wait  [2];
  int          m_err   [2];
  logic        m_pw_v  [2];
  int          m_pw_idx[2];
  logic [3:0]  m_pw_be [2];

  // Values sampled at the falling edge preceding each rising edge
  logic        c_sel  [2];
  logic        c_wr   [2];
  logic [1:0]  c_trans[2];
  logic [2:0]  c_size [2];
  logic [31:0] c_addr [2];
  logic [31:0] c_wd   [2];
  logic        d_rdy  [2];
  logic        d_resp [2];
  logic [31:0] d_rdata[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rdy[i] = 1'b1; m_resp[i] = 1'b0; m_rdata[i] = 32'd0;
      m_wait[i] = 0; m_err[i] = 0; m_pw_v[i] = 1'b0;
    end
  endtask

  task automatic sample();
    d_rdy[0] = hready0; d_resp[0] = hresp0; d_rdata[0] = hrdata0;
    d_rdy[1] = hready1; d_resp[1] = hresp1; d_rdata[1] = hrdata1;
    for (int i = 0; i < 2; i++) begin
      c_sel[i] = hsel_v[i]; c_wr[i] = hwrite_v[i]; c_trans[i] = htrans_v[i];
      c_size[i] = hsize_v[i]; c_addr[i] = haddr_v[i]; c_wd[i] = hwdata_v[i];
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("inst%0d hready", i), d_rdy[i], m_rdy[i]);
      chk1($sformatf("inst%0d hresp", i), d_resp[i], m_resp[i]);
      chk($sformatf("inst%0d hrdata", i), d_rdata[i], m_rdata[i]);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic acc;
      int   nb, off, base, idx, ws;
      ws = (i == 0) ? 0 : 2;
      if (!hresetn) begin
        m_rdy[i] = 1'b1; m_resp[i] = 1'b0; m_rdata[i] = 32'd0;
        m_wait[i] = 0; m_err[i] = 0; m_pw_v[i] = 1'b0;
      end else begin
        if (m_pw_v[i] && m_rdy[i]) begin
          for (int b = 0; b < 4; b++)
            if (m_pw_be[i][b]) m_mem[i][m_pw_idx[i]][b*8 +: 8] = c_wd[i][b*8 +: 8];
          m_pw_v[i] = 1'b0;
        end
        acc = c_sel[i] && (c_trans[i] == HASTI_TRANS_NONSEQ || c_trans[i] == HASTI_TRANS_SEQ)
              && m_rdy[i];
        if (m_err[i] == 1) begin
          m_err[i] = 2; m_rdy[i] = 1'b1; m_resp[i] = 1'b1;
        end else if (m_wait[i] > 0) begin
          m_wait[i]--; m_rdy[i] = (m_wait[i] == 0); m_resp[i] = 1'b0;
        end else begin
          m_err[i] = 0; m_rdy[i] = 1'b1; m_resp[i] = 1'b0;
        end
        if (acc) begin
          nb  = 1 << c_size[i];
          off = int'(c_addr[i][1:0]);
          idx = int'(c_addr[i][AB-1:2]);
          if (c_size[i] > 3'd2 || (off % nb) != 0) begin
            m_err[i] = 1; m_rdy[i] = 1'b0; m_resp[i] = 1'b1;
          end else begin
            base = off - (off % nb);
            m_err[i] = 0; m_resp[i] = 1'b0; m_wait[i] = ws; m_rdy[i] = (ws == 0);
            if (c_wr[i]) begin
              m_pw_v[i] = 1'b1; m_pw_idx[i] = idx;
              for (int b = 0; b < 4; b++) m_pw_be[i][b] = (b >= base && b < base + nb);
            end else begin
              m_rdata[i] = m_mem[i][idx];
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Present one address phase (plus data for the previous transfer) and hold it until taken.
  task automatic step(input int i, input logic [1:0] trans, input logic [31:0] addr,
                      input logic wr, input logic [2:0] size, input logic [31:0] wd,
                      output int ticks);
    hsel_v[i] = 1'b1; htrans_v[i] = trans; haddr_v[i] = addr;
    hwrite_v[i] = wr; hsize_v[i] = size; hwdata_v[i] = wd;
    $display("[TB] inst%0d trans=%0d addr=0x%08h wr=%0d size=%0d wdata=0x%08h",
             i, trans, addr, wr, size, wd);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!d_rdy[i] && ticks < 20);
    if (!d_rdy[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL inst%0d accept timeout: hready stayed 0, required 1", i);
    end
  endtask

  localparam logic [1:0] NS = HASTI_TRANS_NONSEQ;
  localparam logic [1:0] SQ = HASTI_TRANS_SEQ;
  localparam logic [1:0] ID = HASTI_TRANS_IDLE;

  initial begin
    int t;
    hresetn = 1'b0;
    hsel_v = '0; hwrite_v = '0; htrans_v = '0; hsize_v = '0; haddr_v = '0; hwdata_v = '0;
    model_reset();
    tick();
    tick();
    chk1("reset hready", hready0, 1'b1);
    chk1("reset hresp", hresp0, 1'b0);
    chk("reset hrdata", hrdata0, 32'h0);
    hresetn = 1'b1;
    tick();

    // ---- instance 0: no wait states ----
    step(0, NS, 32'h100, 1'b1, 3'd2, 32'h0, t);
    step(0, NS, 32'h100, 1'b0, 3'd2, 32'hDEADBEEF, t);
    chk("word read", hrdata0, 32'hDEADBEEF);
    chk1("word read hready", hready0, 1'b1);
    chk1("word read hresp", hresp0, 1'b0);

    step(0, NS, 32'h200, 1'b1, 3'd2, 32'h0, t);
    step(0, NS, 32'h202, 1'b1, 3'd0, 32'h11223344, t);
    step(0, NS, 32'h204, 1'b1, 3'd2, 32'h00AA0000, t);
    step(0, NS, 32'h206, 1'b1, 3'd1, 32'h00000000, t);
    step(0, NS, 32'h200, 1'b0, 3'd2, 32'hBEEF0000, t);
    chk("byte merge", hrdata0, 32'h11AA3344);
    step(0, NS, 32'h204, 1'b0, 3'd2, 32'h0, t);
    chk("half merge", hrdata0, 32'hBEEF0000);

    step(0, NS, 32'h300, 1'b1, 3'd2, 32'h0, t);
    step(0, NS, 32'h300, 1'b0, 3'd2, 32'hCAFEF00D, t);
    chk("raw word fwd", hrdata0, 32'hCAFEF00D);
    step(0, SQ, 32'h301, 1'b1, 3'd0, 32'h0, t);
    step(0, NS, 32'h300, 1'b0, 3'd2, 32'h00005500, t);
    chk("raw byte fwd", hrdata0, 32'hCAFE550D);

    step(0, NS, 32'h4010, 1'b1, 3'd2, 32'h0, t);
    step(0, NS, 32'h0010, 1'b0, 3'd2, 32'hA5A5C3C3, t);
    chk("addr wrap", hrdata0, 32'hA5A5C3C3);

    step(0, NS, 32'h102, 1'b0, 3'd2, 32'h0, t);
    chk1("err word@102 hready", hready0, 1'b0);
    chk1("err word@102 hresp", hresp0, 1'b1);
    tick();
    chk1("errdone word@102 hready", hready0, 1'b1);
    chk1("errdone word@102 hresp", hresp0, 1'b1);
    step(0, NS, 32'h101, 1'b1, 3'd1, 32'h0, t);
    chk1("err half@101 hready", hready0, 1'b0);
    chk1("err half@101 hresp", hresp0, 1'b1);
    tick();
    chk1("errdone half@101 hresp", hresp0, 1'b1);
    step(0, NS, 32'h100, 1'b0, 3'd3, 32'h77777777, t);
    chk1("err size3 hready", hready0, 1'b0);
    chk1("err size3 hresp", hresp0, 1'b1);
    tick();
    chk1("errdone size3 hready", hready0, 1'b1);
    step(0, NS, 32'h100, 1'b0, 3'd2, 32'h0, t);
    chk("post-error read", hrdata0, 32'hDEADBEEF);
    chk1("post-error hresp", hresp0, 1'b0);
    step(0, ID, 32'h0, 1'b0, 3'd0, 32'h0, t);
    hsel_v[0] = 1'b0;

    // ---- instance 1: two wait states ----
    step(1, NS, 32'h100, 1'b1, 3'd2, 32'h0, t);
    step(1, NS, 32'h100, 1'b0, 3'd2, 32'h01020304, t);
    chk("ws write hold cycles", t, 32'd3);
    chk1("ws read hready low", hready1, 1'b0);
    chk("ws read data in wait", hrdata1, 32'h01020304);
    step(1, NS, 32'h104, 1'b1, 3'd2, 32'h0, t);
    chk("ws held addr cycles", t, 32'd3);
    chk("ws rdata held", hrdata1, 32'h01020304);
    step(1, NS, 32'h400, 1'b1, 3'd2, 32'h55667788, t);
    step(1, NS, 32'h400, 1'b1, 3'd2, 32'h12345678, t);
    hwdata_v[1] = 32'hFFFFFFFF; htrans_v[1] = ID; hsel_v[1] = 1'b0;
    #2;
    hresetn = 1'b0;
    model_reset();
    #1;
    chk1("async rst hready", hready1, 1'b1);
    chk1("async rst hresp", hresp1, 1'b0);
    chk("async rst hrdata", hrdata1, 32'h0);
    tick();
    tick();
    hresetn = 1'b1;
    tick();
    step(1, NS, 32'h400, 1'b0, 3'd2, 32'h0, t);
    chk("rst aborted write", hrdata1, 32'h12345678);
    step(1, NS, 32'h104, 1'b0, 3'd2, 32'h0, t);
    chk("ws second read", hrdata1, 32'h55667788);
    step(1, ID, 32'h0, 1'b0, 3'd0, 32'h0, t);
    hsel_v[1] = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_sram_slave.md
Name: vscale_hasti_sram_slave

Overview:
AHB-lite (HASTI) responder for the inst/data scratchpads, the slave end of the crossbar's `is_*`/`ds_*` ports.
- Byte-addressed, word-wide SRAM with byte-lane writes.
- Programmable wait states.
- Two-cycle ERROR response for illegal transfers.
- Read-after-write forwarding.
- One instance per scratchpad; it drives its own `hready`/`hresp` back to the crossbar.

Parameters:
- `ADDR_BITS`, default 14: byte-address bits decoded; depth = 2^(ADDR_BITS-2) words (4096).
- `WAIT_STATES`, default 0: data-phase wait cycles inserted per accepted transfer, range 0..3.

Ports:
- `hclk` input 1: clock, all state on rising edge.
- `hresetn` input 1: asynchronous, active-low reset.
- `hsel` input 1: slave select from the crossbar.
- `haddr` input `HASTI_ADDR_WIDTH`: byte address; only [ADDR_BITS-1:0] is used.
- `hwrite` input 1: 1 = write.
- `hsize` input `HASTI_SIZE_WIDTH`: 0 byte, 1 half, 2 word.
- `hburst` input `HASTI_BURST_WIDTH`: ignored (each beat is treated independently).
- `hmastlock` input 1: ignored.
- `hprot` input `HASTI_PROT_WIDTH`: ignored.
- `htrans` input `HASTI_TRANS_WIDTH`: IDLE/BUSY/NONSEQ/SEQ.
- `hwdata` input `HASTI_BUS_WIDTH`: write data, valid in the data phase.
- `hrdata` output `HASTI_BUS_WIDTH`: read data.
- `hready` output 1: transfer done / slave ready.
- `hresp` output 1: 0 OKAY, 1 ERROR.

Behaviour:
- **Reset** (async, `hresetn`=0): `hready`=1, `hresp`=0, `hrdata`=0, state S_READY, wait counter 0, pending write dropped. SRAM contents are not cleared.
- **Accept.** An address phase is accepted on a rising edge when `hsel` && `htrans`∈{NONSEQ,SEQ} && `hready`=1. IDLE/BUSY, or `hsel`=0, produce no data phase: the next state is S_READY with OKAY.
- **Legality.** A transfer is illegal if `hsize`>2, or if `hsize`=1 and `haddr[0]`=1, or if `hsize`=2 and `haddr[1:0]`≠0.
  - Illegal transfer: next state S_ERR (`hready`=0, `hresp`=1), then S_ERRDONE (`hready`=1, `hresp`=1), then continue.
  - No SRAM write and no `hrdata` update for an illegal transfer.
- **Legal transfer, WAIT_STATES=0:** the data phase is the next cycle, with `hready`=1 and `hresp`=0.
- **Legal transfer, WAIT_STATES=N>0:** state S_WAIT for N cycles (`hready`=0), counter loads N-1 and decrements, then S_READY.
  - An address presented while `hready`=0 is not accepted and must be held by the master.
- **Lanes** (little-endian): byte → lane `haddr[1:0]`; half → lanes {`haddr[1]`,0..1}; word → all 4 lanes.
- **Write.**
  - Address phase registers word index and byte-enables.
  - `hwdata` is captured and committed to the SRAM on the edge ending the data phase (`hready`=1), byte lanes only.
  - Other bytes of the word are unchanged.
- **Read.**
  - The SRAM is read synchronously at the accepting edge.
  - `hrdata` is valid for the whole data phase, including every wait cycle, and holds its value until the next read completes.
  - `hrdata` returns the full word regardless of `hsize`; the master extracts lanes.
- **RAW hazard.** When a read address is accepted on the same edge a write data phase commits to the same word index, `hrdata` = merge(old word, `hwdata` on enabled lanes). Lanes that were not written read the old value.
- **Back-to-back:** with WAIT_STATES=0 there is one transfer per cycle indefinitely, with no bubbles between read/write mixes.
- **Reset mid-operation:**
  - Reset during S_WAIT aborts the pending write (SRAM is not modified).
  - Reset during S_ERR yields `hready`=1, `hresp`=0 immediately.
- **Address wrap:** bits above ADDR_BITS are ignored; 0x4000 aliases 0x0000.

Decomposition:
- Shared header `vscale_hasti_constants.vh`: `HASTI_TRANS_{IDLE,BUSY,NONSEQ,SEQ}`, `HASTI_SIZE_{BYTE,HALFWORD,WORD}`, `HASTI_RESP_{OKAY,ERROR}`, widths. Add missing SIZE/RESP defines there, not locally.
- Local state encoding: S_READY, S_WAIT, S_ERR, S_ERRDONE.
- One sub-module, `vscale_sram_1rw_be`: behavioural single-port-plus-write byte-enable synchronous RAM (`clk`, `we[3:0]`, `waddr`, `wdata`, `raddr`, `rdata`), with write-before-read forwarding kept in the parent.

Test Plan:
- **Word write/read.** WAIT_STATES=0: NONSEQ write 0x100 size 2 data 0xDEADBEEF, then NONSEQ read 0x100 → `hrdata`=0xDEADBEEF in the read data phase; `hready` stays 1 and `hresp` 0 throughout.
- **Byte merge.** Word 0x200=0x11223344; write byte 0x202 data 0x00AA0000 → read 0x200 returns 0x11AA3344. Halfword write 0x206 data 0xBEEF0000 over zeros → read 0x204 returns 0xBEEF0000.
- **RAW forward.** Write word 0x300=0xCAFEF00D with read 0x300 accepted during its data phase → `hrdata`=0xCAFEF00D the next cycle. The same test with a byte write to 0x301 shows only lane 1 forwarded.
- **Wait states.** WAIT_STATES=2: read 0x100 → `hready` low for exactly 2 cycles, then high with data; a held next address is accepted only on the `hready`=1 edge.
- **Error.** Word read at 0x102, halfword write at 0x101, and hsize=3 each give `hready`=0/`hresp`=1 then `hready`=1/`hresp`=1. The SRAM is unchanged (read back 0x100 is intact), and a following legal transfer returns OKAY.
- **Async reset.** Assert `hresetn` mid-S_WAIT of a write to 0x400 (old value 0x12345678) → outputs go to reset values without a clock edge; after release, 0x400 reads 0x12345678.
